vdma_arbiter: RTL and testbench



---
 rtl/vdma_pkg.sv | 31 +++
 rtl/vdma_buf_mgr.sv | 96 +++++++++
 rtl/vdma_arbiter.sv | 154 +++++++++++++++
 tb/tb_vdma_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdma_pkg.sv
`timescale 1ns/1ps
// vdma_pkg: shared types and default frame geometry for the video DMA
// DDR arbiter (FSM states, buffer index type, channel select codes).
package vdma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef logic [1:0] buf_idx_t;
    typedef logic       ch_sel_t;

    localparam ch_sel_t CH_RD = 1'b0;
    localparam ch_sel_t CH_WR = 1'b1;

    // 1280x720x16 bit frame, 256-bit beats, 16 beats per burst
    localparam int DEF_ADDR_W       = 28;
    localparam int DEF_BURST_BEATS  = 16;
    localparam int DEF_ADDR_STEP    = 128;
    localparam int DEF_FRAME_BURSTS = 3600;
    localparam int DEF_FRAME_STRIDE = 32'h0020_0000;
    localparam int DEF_CNT_W        = 12;

    // The one buffer index (of 0..2) used by neither a nor b.
    function automatic buf_idx_t third_buf(input buf_idx_t a, input buf_idx_t b);
        return buf_idx_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/vdma_buf_mgr.sv
`timescale 1ns/1ps
// vdma_buf_mgr: triple frame-buffer bookkeeping. Latches frame-start pulses,
// applies write/read buffer swaps only while the arbiter is idle, tracks the
// latest completed frame. VDMA_ARB_STAT_EN adds drop/repeat counters.
module vdma_buf_mgr
    import vdma_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_frame_start,
    input  logic     rd_frame_start,
    input  logic     fsm_idle,
    input  logic     wr_frame_full,
    output buf_idx_t wr_buf_idx,
    output buf_idx_t rd_buf_idx,
    output logic     swap_busy,
    output logic     wr_swap,
    output logic     rd_swap
`ifdef VDMA_ARB_STAT_EN
    ,
    output logic [15:0] stat_wr_drop,
    output logic [15:0] stat_rd_repeat
`endif
);

    logic     wr_pend_q, wr_pend_d;
    logic     rd_pend_q, rd_pend_d;
    buf_idx_t wr_idx_q, wr_idx_d;
    buf_idx_t rd_idx_q, rd_idx_d;
    buf_idx_t latest_q, latest_d;

    // A pending flag in idle always performs its swap in that same cycle.
    assign wr_swap    = fsm_idle && wr_pend_q;
    assign rd_swap    = fsm_idle && rd_pend_q;
    assign swap_busy  = wr_pend_q || rd_pend_q;
    assign wr_buf_idx = wr_idx_q;
    assign rd_buf_idx = rd_idx_q;

    // Swap ordering: write swap first so a simultaneous read picks up the new latest.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        latest_d = latest_q;
        if (wr_swap && wr_frame_full) begin
            latest_d = wr_idx_q;
            wr_idx_d = third_buf(wr_idx_q, rd_idx_q);
        end
        if (rd_swap) begin
            rd_idx_d = latest_d;
        end
        wr_pend_d = wr_frame_start || (wr_pend_q && !wr_swap);
        rd_pend_d = rd_frame_start || (rd_pend_q && !rd_swap);
    end

    // Buffer index and pending-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_idx_q  <= 2'd0;
            rd_idx_q  <= 2'd1;
            latest_q  <= 2'd1;
        end else begin
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            latest_q  <= latest_d;
        end
    end

`ifdef VDMA_ARB_STAT_EN
    logic [15:0] drop_q, repeat_q;
    logic        drop_inc, repeat_inc;

    assign drop_inc       = wr_swap && !wr_frame_full;
    assign repeat_inc     = rd_swap && (latest_d == rd_idx_q);
    assign stat_wr_drop   = drop_q;
    assign stat_rd_repeat = repeat_q;

    // Saturating counters of dropped write frames and repeated read frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q   <= '0;
            repeat_q <= '0;
        end else begin
            if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            if (repeat_inc && (repeat_q != 16'hFFFF)) repeat_q <= repeat_q + 16'd1;
        end
    end
`endif

    a_buf_invariant: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_idx_q != rd_idx_q) && (latest_q != wr_idx_q));

endmodule

// File: rtl/vdma_arbiter.sv
`timescale 1ns/1ps
// vdma_arbiter: shares one DDR command port between the video write channel
// and the HDMI read channel, with burst counters, address generation and a
// triple-buffer manager. Defining VDMA_ARB_STAT_EN adds statistics outputs.
module vdma_arbiter
    import vdma_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                BURST_BEATS  = DEF_BURST_BEATS,
    parameter int                ADDR_STEP    = DEF_ADDR_STEP,
    parameter int                FRAME_BURSTS = DEF_FRAME_BURSTS,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(DEF_FRAME_STRIDE),
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic              cmd_ready,
    input  logic              burst_done,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wr_grant,
    output logic              rd_grant,
    output logic [1:0]        wr_buf_idx,
    output logic [1:0]        rd_buf_idx
`ifdef VDMA_ARB_STAT_EN
    ,
    output logic [15:0]       stat_wr_drop,
    output logic [15:0]       stat_rd_repeat
`endif
);

    if (((1 << CNT_W) <= FRAME_BURSTS) || (BURST_BEATS < 1)) begin : g_cfg_check
        $error("vdma_arbiter: CNT_W too small for FRAME_BURSTS or BURST_BEATS < 1");
    end

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BURSTS);

    arb_state_e        state_q, state_d;
    ch_sel_t           sel_q, sel_d;
    ch_sel_t           last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    ch_sel_t           pick;
    buf_idx_t          pick_buf;
    logic [CNT_W-1:0]  pick_cnt;
    logic              wr_elig, rd_elig;
    logic              swap_busy, wr_swap, rd_swap;
    buf_idx_t          wr_idx, rd_idx;

    vdma_buf_mgr u_buf_mgr (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .fsm_idle       (state_q == IDLE),
        .wr_frame_full  (wr_cnt_q == CNT_FULL),
        .wr_buf_idx     (wr_idx),
        .rd_buf_idx     (rd_idx),
        .swap_busy      (swap_busy),
        .wr_swap        (wr_swap),
        .rd_swap        (rd_swap)
`ifdef VDMA_ARB_STAT_EN
        ,
        .stat_wr_drop   (stat_wr_drop),
        .stat_rd_repeat (stat_rd_repeat)
`endif
    );

    assign wr_elig    = wr_req && (wr_cnt_q < CNT_FULL);
    assign rd_elig    = rd_req && (rd_cnt_q < CNT_FULL);
    assign cmd_valid  = (state_q == CMD);
    assign cmd_write  = sel_q;
    assign cmd_addr   = addr_q;
    assign wr_grant   = (state_q == DATA) && (sel_q == CH_WR);
    assign rd_grant   = (state_q == DATA) && (sel_q == CH_RD);
    assign wr_buf_idx = wr_idx;
    assign rd_buf_idx = rd_idx;

    // Next-state logic: arbitration in IDLE (pending swaps win), command hold, burst completion.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        pick     = CH_RD;
        if (rd_elig && rd_urgent) begin
            pick = CH_RD;
        end else if (wr_elig && rd_elig) begin
            pick = (last_q == CH_RD) ? CH_WR : CH_RD;
        end else if (wr_elig) begin
            pick = CH_WR;
        end
        pick_buf = (pick == CH_WR) ? wr_idx : rd_idx;
        pick_cnt = (pick == CH_WR) ? wr_cnt_q : rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (!swap_busy && en && (wr_elig || rd_elig)) begin
                    state_d = CMD;
                    sel_d   = pick;
                    last_d  = pick;
                    addr_d  = ADDR_W'(pick_buf) * FRAME_STRIDE
                            + ADDR_W'(pick_cnt) * ADDR_W'(ADDR_STEP);
                end
            end
            CMD: begin
                if (cmd_ready) state_d = DATA;
            end
            DATA: begin
                if (burst_done) begin
                    state_d = IDLE;
                    if (sel_q == CH_WR) begin
                        if (wr_cnt_q < CNT_FULL) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end else begin
                        if (rd_cnt_q < CNT_FULL) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_swap) wr_cnt_d = '0;
        if (rd_swap) rd_cnt_d = '0;
    end

    // State, selection, address and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= CH_RD;
            last_q   <= CH_RD;
            addr_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_vdma_arbiter.sv
`timescale 1ns/1ps
// tb_vdma_arbiter: directed scenarios for the video DMA arbiter with a
// simple DDR responder and a command log. Stat checks need VDMA_ARB_STAT_EN.
module tb_vdma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, en, wr_frame_start, rd_frame_start;
    logic        wr_req, rd_req, rd_urgent, cmd_ready, burst_done;
    logic        cmd_valid, cmd_write, wr_grant, rd_grant;
    logic [27:0] cmd_addr;
    logic [1:0]  wr_buf_idx, rd_buf_idx;
`ifdef VDMA_ARB_STAT_EN
    logic [15:0] stat_wr_drop, stat_rd_repeat;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 4;
    int gcnt = 0;
    logic [27:0] log_addr[$];
    bit          log_wr[$];

    vdma_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .rd_urgent      (rd_urgent),
        .cmd_ready      (cmd_ready),
        .burst_done     (burst_done),
        .cmd_valid      (cmd_valid),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .wr_grant       (wr_grant),
        .rd_grant       (rd_grant),
        .wr_buf_idx     (wr_buf_idx),
        .rd_buf_idx     (rd_buf_idx)
`ifdef VDMA_ARB_STAT_EN
        ,
        .stat_wr_drop   (stat_wr_drop),
        .stat_rd_repeat (stat_rd_repeat)
`endif
    );

    always #5 clk = ~clk;

    // DDR responder: pulse burst_done lat cycles after a grant appears.
    initial begin
        burst_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || burst_done) begin
                burst_done = 1'b0;
                gcnt = 0;
            end else if (wr_grant || rd_grant) begin
                gcnt++;
                if (gcnt >= lat) burst_done = 1'b1;
            end
        end
    end

    // Command log: one entry per accepted command.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                log_addr.push_back(cmd_addr);
                log_wr.push_back(cmd_write);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cmds(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (log_addr.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0; cmd_ready = 1'b0;
        wait_clks(3);
        log_addr.delete();
        log_wr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b expected 0", cmd_valid); end
        if (cmd_write !== 1'b0) begin errors++; $display("FAIL rst_cmd_write: got %b expected 0", cmd_write); end
        if (cmd_addr !== 28'h0) begin errors++; $display("FAIL rst_cmd_addr: got %h expected 0", cmd_addr); end
        if (wr_grant !== 1'b0) begin errors++; $display("FAIL rst_wr_grant: got %b expected 0", wr_grant); end
        if (rd_grant !== 1'b0) begin errors++; $display("FAIL rst_rd_grant: got %b expected 0", rd_grant); end
        if (wr_buf_idx !== 2'd0) begin errors++; $display("FAIL rst_wr_buf: got %0d expected 0", wr_buf_idx); end
        if (rd_buf_idx !== 2'd1) begin errors++; $display("FAIL rst_rd_buf: got %0d expected 1", rd_buf_idx); end
`ifdef VDMA_ARB_STAT_EN
        checks++;
        if (stat_wr_drop !== 16'd0 || stat_rd_repeat !== 16'd0) begin
            errors++; $display("FAIL rst_stats: got %h/%h expected 0/0", stat_wr_drop, stat_rd_repeat);
        end
`endif
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [27:0] exp_a [4] = '{28'h0000000, 28'h0200000, 28'h0000080, 28'h0200080};
        bit          exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        lat = 2; en = 1'b1; cmd_ready = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wait_cmds(4, 200, ok);
        wr_req = 1'b0; rd_req = 1'b0;
        wait_clks(10);
        checks++;
        if (!ok || log_addr.size() != 4) begin
            errors++; $display("FAIL rr_count: got %0d commands expected 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_wr[i] !== exp_w[i] || log_addr[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL rr_cmd[%0d]: got write=%b addr=%h expected write=%b addr=%h",
                             i, log_wr[i], log_addr[i], exp_w[i], exp_a[i]);
                end
            end
        end
        $display("rr: %0d commands logged", log_addr.size());
    endtask

    task automatic test_urgent();
        bit ok;
        logic [27:0] exp_a [4] = '{28'h0200100, 28'h0200180, 28'h0200200, 28'h0200280};
        log_addr.delete(); log_wr.delete();
        rd_urgent = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wait_cmds(4, 200, ok);
        wr_req = 1'b0; rd_req = 1'b0;
        wait_clks(10);
        rd_urgent = 1'b0;
        checks++;
        if (!ok || log_addr.size() != 4) begin
            errors++; $display("FAIL urgent_count: got %0d commands expected 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_wr[i] !== 1'b0 || log_addr[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL urgent_cmd[%0d]: got write=%b addr=%h expected write=0 addr=%h",
                             i, log_wr[i], log_addr[i], exp_a[i]);
                end
            end
        end
        $display("urgent: %0d commands logged", log_addr.size());
    endtask

    task automatic test_write_only();
        bit ok;
        int n_rd;
        do_reset();
        lat = 4; en = 1'b1; cmd_ready = 1'b1; wr_req = 1'b1;
        wait_cmds(3600, 40000, ok);
        wait_clks(40);
        n_rd = 0;
        foreach (log_wr[i]) if (!log_wr[i]) n_rd++;
        checks += 2;
        if (!ok || log_addr.size() != 3600) begin
            errors++; $display("FAIL wo_count: got %0d commands expected 3600", log_addr.size());
        end
        if (cmd_valid !== 1'b0 || n_rd != 0) begin
            errors++; $display("FAIL wo_stop: got cmd_valid=%b reads=%0d expected 0/0", cmd_valid, n_rd);
        end
        if (log_addr.size() == 3600) begin
            checks += 2;
            if (log_addr[0] !== 28'h0 || log_addr[1] !== 28'h80 || log_addr[2] !== 28'h100) begin
                errors++; $display("FAIL wo_first_addrs: got %h %h %h expected 0 80 100",
                                   log_addr[0], log_addr[1], log_addr[2]);
            end
            if (log_addr[3599] !== 28'h0070780) begin
                errors++; $display("FAIL wo_last_addr: got %h expected 0070780", log_addr[3599]);
            end
        end
        wr_req = 1'b0;
        $display("write_only: %0d commands logged", log_addr.size());
    endtask

    task automatic test_frame_swap();
        bit ok;
        wr_frame_start = 1'b1; wait_clks(1); wr_frame_start = 1'b0;
        wait_clks(3);
        checks++;
        if (wr_buf_idx !== 2'd2 || rd_buf_idx !== 2'd1) begin
            errors++; $display("FAIL swap_wr: got wr=%0d rd=%0d expected wr=2 rd=1", wr_buf_idx, rd_buf_idx);
        end
        rd_frame_start = 1'b1; wait_clks(1); rd_frame_start = 1'b0;
        wait_clks(3);
        checks++;
        if (rd_buf_idx !== 2'd0 || wr_buf_idx !== 2'd2) begin
            errors++; $display("FAIL swap_rd: got wr=%0d rd=%0d expected wr=2 rd=0", wr_buf_idx, rd_buf_idx);
        end
        log_addr.delete(); log_wr.delete();
        rd_req = 1'b1;
        wait_cmds(1, 50, ok);
        rd_req = 1'b0;
        wait_clks(10);
        checks++;
        if (!ok || log_wr[0] !== 1'b0 || log_addr[0] !== 28'h0) begin
            errors++; $display("FAIL swap_rd_addr: got ok=%b cmds=%0d expected one read at 0000000", ok, log_addr.size());
        end
        $display("frame_swap: wr_buf=%0d rd_buf=%0d", wr_buf_idx, rd_buf_idx);
    endtask

    task automatic test_wr_drop();
        bit ok;
        log_addr.delete(); log_wr.delete();
        wr_req = 1'b1;
        wait_cmds(100, 1500, ok);
        wr_req = 1'b0;
        wait_clks(10);
        checks++;
        if (!ok || log_addr.size() != 100 || log_addr[0] !== 28'h0400000 || log_addr[99] !== 28'h0403180) begin
            errors++; $display("FAIL drop_fill: got %0d commands expected 100 from 0400000 to 0403180", log_addr.size());
        end
        wr_frame_start = 1'b1; wait_clks(1); wr_frame_start = 1'b0;
        wait_clks(3);
        checks++;
        if (wr_buf_idx !== 2'd2 || rd_buf_idx !== 2'd0) begin
            errors++; $display("FAIL drop_bufs: got wr=%0d rd=%0d expected wr=2 rd=0", wr_buf_idx, rd_buf_idx);
        end
        log_addr.delete(); log_wr.delete();
        wr_req = 1'b1;
        wait_cmds(1, 50, ok);
        wr_req = 1'b0;
        wait_clks(10);
        checks++;
        if (!ok || log_addr[0] !== 28'h0400000) begin
            errors++; $display("FAIL drop_restart: got ok=%b cmds=%0d expected write at 0400000", ok, log_addr.size());
        end
`ifdef VDMA_ARB_STAT_EN
        checks++;
        if (stat_wr_drop !== 16'd1 || stat_rd_repeat !== 16'd0) begin
            errors++; $display("FAIL drop_stats: got %0d/%0d expected 1/0", stat_wr_drop, stat_rd_repeat);
        end
`endif
        $display("wr_drop: wr_buf=%0d", wr_buf_idx);
    endtask

    task automatic test_simultaneous();
        bit ok, gone;
        lat = 2;
        log_addr.delete(); log_wr.delete();
        wr_req = 1'b1;
        wait_cmds(3599, 30000, ok);
        wr_frame_start = 1'b1; rd_frame_start = 1'b1; rd_req = 1'b1;
        wait_clks(1);
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL sim_fill: got %0d commands expected 3599", log_addr.size()); end
        gone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wr_grant) begin gone = 1'b1; break; end
        end
        checks += 3;
        if (!gone || cmd_valid !== 1'b0 || wr_buf_idx !== 2'd2) begin
            errors++; $display("FAIL sim_idle1: got valid=%b wr=%0d expected valid=0 wr=2", cmd_valid, wr_buf_idx);
        end
        @(negedge clk);
        if (cmd_valid !== 1'b0 || wr_buf_idx !== 2'd1 || rd_buf_idx !== 2'd2) begin
            errors++; $display("FAIL sim_swap: got valid=%b wr=%0d rd=%0d expected valid=0 wr=1 rd=2",
                               cmd_valid, wr_buf_idx, rd_buf_idx);
        end
        @(negedge clk);
        if (cmd_valid !== 1'b1 || cmd_write !== 1'b0 || cmd_addr !== 28'h0400000) begin
            errors++; $display("FAIL sim_first_cmd: got valid=%b write=%b addr=%h expected valid=1 write=0 addr=0400000",
                               cmd_valid, cmd_write, cmd_addr);
        end
        wait_cmds(3601, 100, ok);
        wr_req = 1'b0; rd_req = 1'b0;
        wait_clks(10);
        checks++;
        if (!ok || log_wr[3600] !== 1'b1 || log_addr[3600] !== 28'h0200000) begin
            errors++; $display("FAIL sim_next_wr: got ok=%b cmds=%0d expected write at 0200000", ok, log_addr.size());
        end
        $display("simultaneous: wr_buf=%0d rd_buf=%0d", wr_buf_idx, rd_buf_idx);
    endtask

    task automatic test_stall();
        lat = 4;
        rd_frame_start = 1'b1; wait_clks(1); rd_frame_start = 1'b0;
        wait_clks(3);
        checks++;
        if (rd_buf_idx !== 2'd2) begin
            errors++; $display("FAIL repeat_rd_buf: got %0d expected 2", rd_buf_idx);
        end
`ifdef VDMA_ARB_STAT_EN
        checks++;
        if (stat_rd_repeat !== 16'd1) begin
            errors++; $display("FAIL repeat_stat: got %0d expected 1", stat_rd_repeat);
        end
`endif
        cmd_ready = 1'b0; wr_req = 1'b1;
        wait_clks(3);
        wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || cmd_addr !== 28'h0200080) begin
                errors++; $display("FAIL stall[%0d]: got valid=%b write=%b addr=%h expected 1 1 0200080",
                                   i, cmd_valid, cmd_write, cmd_addr);
            end
            wait_clks(1);
        end
        cmd_ready = 1'b1;
        wait_clks(1);
        checks++;
        if (cmd_valid !== 1'b0 || wr_grant !== 1'b1) begin
            errors++; $display("FAIL stall_accept: got valid=%b wr_grant=%b expected 0 1", cmd_valid, wr_grant);
        end
        wait_clks(10);
        $display("stall: held 10 cycles");
    endtask

    task automatic test_async_reset();
        bit seen;
        lat = 50; rd_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_clks(1);
            if (rd_grant) begin seen = 1'b1; break; end
        end
        rd_req = 1'b0;
        wait_clks(2);
        checks++;
        if (!seen || rd_grant !== 1'b1 || cmd_addr !== 28'h0400000) begin
            errors++; $display("FAIL ar_pre: got rd_grant=%b addr=%h expected 1 0400000", rd_grant, cmd_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 28'h0 || wr_grant !== 1'b0 ||
            rd_grant !== 1'b0 || wr_buf_idx !== 2'd0 || rd_buf_idx !== 2'd1) begin
            errors++; $display("FAIL ar_outputs: got v=%b w=%b a=%h g=%b%b wb=%0d rb=%0d expected all reset values",
                               cmd_valid, cmd_write, cmd_addr, wr_grant, rd_grant, wr_buf_idx, rd_buf_idx);
        end
        wait_clks(3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(2);
        $display("async_reset: outputs after reset valid=%b rd_grant=%b", cmd_valid, rd_grant);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0; cmd_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_urgent();
        test_write_only();
        test_frame_swap();
        test_wr_drop();
        test_simultaneous();
        test_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
